// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Instruction-fetch initiator. Drives the instruction memory address,
//            captures the combinational instruction word into a small prefetch
//            FIFO of {pc, instr} pairs and hands entries to decode over a
//            valid/ready handshake. A redirect flushes the FIFO and reloads PC.
// Options  : IFETCH_PERF_CNT_EN - enables perf_fetched / perf_stall counters;
//            when undefined both ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] iaddr,
   input  logic [31:0] idata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        misalign,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [31:0] C_RESET_PC = {RESET_PC[31:2], 2'b00};

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_pc_mem    [DEPTH];
   logic [31:0]   r_instr_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_misalign;

   logic          w_valid;
   logic          w_pop;
   logic          w_push;
   logic          w_full;

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == C_DEPTH);
   assign w_pop   = w_valid & out_ready;
   // A full FIFO that pops this cycle frees the slot the push lands in.
   assign w_push  = ~redirect & (~w_full | w_pop);

   assign iaddr     = r_fetch_pc;
   assign out_valid = w_valid;
   // Entries are not reset, so the head is masked while the FIFO is empty.
   assign out_instr = w_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
   assign out_pc    = w_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
   assign misalign  = r_misalign;

   // Fetch PC, pointers, occupancy and misalign pulse; redirect has priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= C_RESET_PC;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_misalign <= 1'b0;
      end else if (redirect) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_misalign <= |redirect_pc[1:0];
      end else begin
         r_misalign <= 1'b0;
         if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_wr_ptr   <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // FIFO storage; contents are only observable through count-qualified reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
         r_instr_mem[r_wr_ptr] <= idata;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_stall;

   // Free-running wrap-around counters; a redirect leaves them untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_fetched <= 32'h0;
         r_perf_stall   <= 32'h0;
      end else begin
         if (w_push) begin
            r_perf_fetched <= r_perf_fetched + 32'd1;
         end
         if (w_full & ~w_pop & ~redirect) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_stall   = r_perf_stall;
`else
   assign perf_fetched = 32'h0;
   assign perf_stall   = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Self-checking bench for ifetch_unit. A queue-based model of the
//            fetch stream is advanced once per clock and compared against all
//            DUT outputs on the falling edge. Directed scenarios are followed
//            by randomized redirect / back-pressure traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        misalign;
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   logic        m_mis;
   logic [31:0] m_fetched;
   logic [31:0] m_stall;

   ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .iaddr        (iaddr),
      .idata        (idata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .misalign     (misalign),
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
   );

   always #5 clk = ~clk;

   // Instruction memory image: word 0 is a NOP (0x00000013).
   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   assign idata = imem(iaddr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc      = {RESET_PC[31:2], 2'b00};
      m_mis     = 1'b0;
      m_fetched = 32'h0;
      m_stall   = 32'h0;
   endtask

   task automatic check_all(input string where);
      logic [63:0] head;
      head = (mq.size() != 0) ? mq[0] : 64'h0;
      check({where, ".valid"},    32'(out_valid), 32'(mq.size() != 0));
      check({where, ".pc"},       out_pc,         head[63:32]);
      check({where, ".instr"},    out_instr,      head[31:0]);
      check({where, ".iaddr"},    iaddr,          m_pc);
      check({where, ".misalign"}, 32'(misalign),  32'(m_mis));
`ifdef IFETCH_PERF_CNT_EN
      check({where, ".fetched"},  perf_fetched,   m_fetched);
      check({where, ".stall"},    perf_stall,     m_stall);
`else
      check({where, ".fetched"},  perf_fetched,   32'h0);
      check({where, ".stall"},    perf_stall,     32'h0);
`endif
   endtask

   // One clock: drive inputs (called just after a falling edge), advance the
   // model across the rising edge, then check on the following falling edge.
   task automatic step(input string where, input logic rd, input logic [31:0] rpc,
                       input logic rdy);
      bit pop, push, stall;
      redirect    = rd;
      redirect_pc = rpc;
      out_ready   = rdy;
      pop   = (mq.size() != 0) && rdy;
      push  = !rd && ((mq.size() < DEPTH) || pop);
      stall = (mq.size() == DEPTH) && !pop && !rd;
      @(posedge clk);
      if (rd) begin
         mq.delete();
         m_pc  = {rpc[31:2], 2'b00};
         m_mis = |rpc[1:0];
      end else begin
         m_mis = 1'b0;
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back({m_pc, imem(m_pc)});
            m_pc      = m_pc + 32'd4;
            m_fetched = m_fetched + 32'd1;
         end
         if (stall) m_stall = m_stall + 32'd1;
      end
      @(negedge clk);
      check_all(where);
   endtask

   task automatic sync_reset_pulse();
      reset = 1'b1;
      redirect = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      model_reset();
      check_all("reset");
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      out_ready   = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all("reset");
      reset = 1'b0;

      // Streaming from reset: first instruction is the NOP at 0
      out_ready = 1'b1;
      step("boot0", 1'b0, 32'h0, 1'b1);
      check("boot0.pc_abs",    out_pc,    32'h0);
      check("boot0.instr_abs", out_instr, 32'h0000_0013);
      for (int i = 0; i < 4; i++) step("stream", 1'b0, 32'h0, 1'b1);

      // Back-pressure: fill to DEPTH and hold
      sync_reset_pulse();
      for (int i = 0; i < 10; i++) step("hold", 1'b0, 32'h0, 1'b0);
      check("hold.iaddr_abs", iaddr,  32'h10);
      check("hold.pc_abs",    out_pc, 32'h0);
      // Pop from full: simultaneous push keeps count at DEPTH
      step("fullpop", 1'b0, 32'h0, 1'b1);
      check("fullpop.pc_abs", out_pc, 32'h4);
      step("fullhold", 1'b0, 32'h0, 1'b0);

      // Redirect with three entries queued
      sync_reset_pulse();
      for (int i = 0; i < 3; i++) step("fill3", 1'b0, 32'h0, 1'b0);
      step("redir200", 1'b1, 32'h200, 1'b1);
      check("redir200.valid_abs", 32'(out_valid), 32'h0);
      step("after200", 1'b0, 32'h0, 1'b1);
      check("after200.pc_abs", out_pc, 32'h200);
      for (int i = 0; i < 3; i++) step("run200", 1'b0, 32'h0, 1'b1);

      // Misaligned redirect
      step("redir206", 1'b1, 32'h206, 1'b1);
      check("redir206.mis_abs", 32'(misalign), 32'h1);
      step("after206", 1'b0, 32'h0, 1'b1);
      check("after206.pc_abs",  out_pc,        32'h204);
      check("after206.mis_abs", 32'(misalign), 32'h0);

      // Address wrap, then asynchronous reset mid-stream
      step("redirTop", 1'b1, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 3; i++) step("wrap", 1'b0, 32'h0, 1'b1);
      check("wrap.pc_abs", out_pc, 32'h0000_0004);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      check_all("async_rel");

      // Randomized redirect / back-pressure traffic
      for (int i = 0; i < 400; i++) begin
         logic rd;
         logic [31:0] rpc;
         rd  = ($urandom_range(0, 9) == 0);
         rpc = $urandom;
         step("rand", rd, rpc, ($urandom_range(0, 2) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch initiator that drives the instruction memory address port and consumes the combinational instruction data returned on it.
- Holds the fetch PC and a small prefetch FIFO of {pc, instruction} pairs.
- Presents fetched instructions to the decode stage over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- iaddr  out  32  instruction memory byte address; always word aligned (bits [1:0] = 0).
- idata  in  32  instruction word returned combinationally for the current iaddr.
- redirect  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode stage accepts the head this cycle.
- out_instr  out  32  instruction word at the FIFO head.
- out_pc  out  32  PC of the FIFO head.
- misalign  out  1  one-cycle pulse: last accepted redirect_pc had non-zero bits [1:0].
- perf_fetched  out  32  fetched-instruction counter (see Optional Feature).
- perf_stall  out  32  full-stall cycle counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, while reset=1):
  - fetch_pc = RESET_PC with bits [1:0] cleared.
  - FIFO count = 0; read and write pointers = 0.
  - out_valid = 0, out_instr = 0, out_pc = 0, misalign = 0, perf counters = 0.
- Combinational outputs:
  - iaddr = fetch_pc.
  - out_valid = (count != 0).
  - out_instr and out_pc come directly from the head entry; no extra register stage.
- pop = out_valid & out_ready.
- push = !redirect & ((count < DEPTH) | pop).
  - A full FIFO with a simultaneous pop still fetches in that cycle.
- On each rising edge, in priority order:
  1. redirect=1:
     - Discard all FIFO entries, including any head being popped this cycle; count = 0.
     - fetch_pc <= {redirect_pc[31:2], 2'b00}.
     - misalign <= |redirect_pc[1:0].
     - Nothing is written this cycle.
  2. Otherwise, if push:
     - Write {fetch_pc, idata} at the write pointer.
     - fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
  3. If pop and no redirect: advance the read pointer.
     - count updates by +push - pop.
  - misalign returns to 0 on every edge without a redirect.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Latency:
  - Instruction at RESET_PC is visible on out_* one cycle after reset deassertion.
  - After a redirect, the target instruction appears on out_* one cycle after the redirect edge.
  - out_valid is 0 in the cycle directly after the redirect edge, then 1 on the next edge.
- Steady state with out_ready=1: one instruction per cycle, no bubbles.
- With out_ready=0: the FIFO fills to DEPTH, then fetch_pc holds and iaddr is stable.
  - The head entry and out_* remain stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation clears all state immediately; no partial entry survives.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined:
  - perf_fetched increments on every push.
  - perf_stall increments on every cycle with count==DEPTH, !pop and !redirect.
  - Both counters wrap at 2^32 and clear on reset. Redirect does not clear them.
- Undefined:
  - Counter logic is not compiled.
  - perf_fetched and perf_stall are tied to 32'h0; ports remain present.

Test Plan:
- Reset release with RESET_PC=0, imem word0=32'h00000013, out_ready=1 -> next cycle out_valid=1, out_pc=0, out_instr=32'h00000013; then out_pc steps 4, 8, 12 on consecutive cycles.
- out_ready=0 for 10 cycles after reset with DEPTH=4 -> count saturates at 4; iaddr holds at 32'h10; out_pc stays 0; perf_stall=6 when IFETCH_PERF_CNT_EN is defined, 0 otherwise.
- FIFO full, then out_ready=1 for one cycle -> head pops and 32'h10 is pushed in the same edge; count stays 4; next out_pc=4.
- redirect=1, redirect_pc=32'h200 while FIFO holds 3 entries and out_ready=1 -> next cycle out_valid=0, iaddr=32'h200; following cycle out_pc=32'h200; no stale entry is ever output.
- redirect_pc=32'h206 -> misalign pulses for exactly one cycle; iaddr=32'h204; first output out_pc=32'h204.
- redirect_pc=32'hFFFF_FFFC, out_ready=1 -> out_pc sequence FFFF_FFFC, 0000_0000, 0000_0004; reset asserted mid-sequence -> out_valid drops to 0 asynchronously.
